// File: rtl/pipe_mem_arbiter_if.sv
// Requester and memory signals of the fetch/data memory arbiter.
// slave = arbiter side, master = requesters plus the memory.
interface pipe_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Each requester raises req and holds its command stable until its
    // one-cycle valid pulse. There is no ready signal. A req seen during
    // the valid cycle is not re-granted.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem, busy
    );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and data stages,
// one transaction at a time, data preferred with a fetch starvation guard.
module pipe_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    pipe_mem_arbiter_if.slave                bus,
    output logic [1:0]                       dbg_state_o,
    output logic [$clog2(STARVE_MAX+1)-1:0]  dbg_starve_o
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_e;

    state_e            state_q;
    owner_e            owner_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              mem_en_q, mem_we_q;
    logic              if_valid_q, d_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
    logic              grant_fetch, grant_data;

    // Data wins unless fetch has already waited out STARVE_MAX data grants.
    always_comb begin
        grant_fetch  = 1'b0;
        grant_data   = 1'b0;
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (bus.d_req && !(bus.if_req && starve_cnt_q == STV_W'(STARVE_MAX)))
                grant_data = 1'b1;
            else if (bus.if_req)
                grant_fetch = 1'b1;

            if (grant_fetch || !bus.if_req)
                starve_cnt_d = '0;
            else if (grant_data && starve_cnt_q != STV_W'(STARVE_MAX))
                starve_cnt_d = starve_cnt_q + STV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_NONE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_valid_q   <= 1'b0;
            d_valid_q    <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                IDLE: begin
                    if (grant_fetch || grant_data) begin
                        owner_q    <= grant_fetch ? OWN_FETCH : OWN_DATA;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= grant_data & bus.d_we;
                        mem_addr_q <= grant_fetch ? bus.if_addr : bus.d_addr;
                        if (grant_data)
                            mem_wdata_q <= bus.d_wdata;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        d_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        lat_cnt_q <= LAT_W'(MEM_LAT);
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                    // Count of 1 marks the cycle mem_rdata is valid.
                    if (lat_cnt_q == LAT_W'(1)) begin
                        if (owner_q == OWN_FETCH) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_valid_q <= 1'b1;
                        end else begin
                            d_rdata_q <= bus.mem_rdata;
                            d_valid_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if_valid_q <= 1'b0;
                    d_valid_q  <= 1'b0;
                    owner_q    <= OWN_NONE;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall_if  = bus.if_req & ~if_valid_q;
    assign bus.stall_mem = bus.d_req & ~d_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign dbg_state_o   = state_q;
    assign dbg_starve_o  = starve_cnt_q;
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter with a latency-accurate memory
// model and a reference memory feeding per-port expected-data queues.
module tb_pipe_mem_arbiter;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_starve;
    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    pipe_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pipe_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .dbg_state_o(dbg_state), .dbg_starve_o(dbg_starve)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    logic [DATA_W-1:0] mem     [0:1023];
    logic [DATA_W-1:0] ref_mem [0:1023];
    logic [DATA_W-1:0] rd_pipe [0:MEM_LAT-1];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        rd_pipe[0] <= mem[bus.mem_addr];
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] if_exp_q[$];
    logic [DATA_W-1:0] d_exp_q[$];
    logic [ADDR_W-1:0] gnt_addr_q[$];
    logic [1:0]        gnt_starve_q[$];
    int                if_cyc_q[$];
    logic [DATA_W-1:0] d_model = '0;
    logic              prev_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.if_valid) begin
            if (if_exp_q.size() == 0) check("if_spurious_valid", 1, 0);
            else check("if_rdata", bus.if_rdata, if_exp_q.pop_front());
            if_cyc_q.push_back(cyc);
        end
        if (bus.d_valid) begin
            if (d_exp_q.size() == 0) check("d_spurious_valid", 1, 0);
            else check("d_rdata", bus.d_rdata, d_exp_q.pop_front());
        end
        if (bus.mem_en) begin
            check("mem_en_gap", prev_en, 0);
            gnt_addr_q.push_back(bus.mem_addr);
            gnt_starve_q.push_back(dbg_starve);
        end
        prev_en = bus.mem_en;
    end

    // ---------------- driver tasks (enter/leave at posedge+1) ----------------
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input bit is_fetch);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = is_fetch ? bus.if_valid : bus.d_valid;
        end
        if (!seen) check(is_fetch ? "if_timeout" : "d_timeout", 0, 1);
        next_cycle();
    endtask

    task automatic fetch_req(input logic [ADDR_W-1:0] a);
        if_exp_q.push_back(ref_mem[a]);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        wait_done(1'b1);
        bus.if_req = 1'b0;
    endtask

    task automatic data_req(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        if (we) ref_mem[a] = wd;
        else d_model = ref_mem[a];
        d_exp_q.push_back(d_model);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        wait_done(1'b0);
        bus.d_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        mem[5] = 32'h2002_0001;
        ref_mem[5] = 32'h2002_0001;
        for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_state", dbg_state, 0);
        check("rst_starve", dbg_starve, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_valids", {bus.if_valid, bus.d_valid}, 0);
        next_cycle();

        // Lone fetch with cycle-exact timing
        if_exp_q.push_back(32'h2002_0001);
        bus.if_req = 1'b1; bus.if_addr = 10'h005;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            check("s1_mem_en", bus.mem_en, c == 1);
            if (c == 1) begin
                check("s1_mem_addr", bus.mem_addr, 10'h005);
                check("s1_mem_we", bus.mem_we, 0);
            end
            check("s1_stall_if", bus.stall_if, c < 4);
            check("s1_if_valid", bus.if_valid, c == 4);
            if (c == 4) check("s1_if_rdata", bus.if_rdata, 32'h2002_0001);
            next_cycle();
        end
        bus.if_req = 1'b0;
        next_cycle();

        // Store, then read it back
        d_exp_q.push_back(d_model);
        ref_mem[10'h010] = 32'hDEAD_BEEF;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 10'h010; bus.d_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            check("s2_mem_en", bus.mem_en, c == 1);
            check("s2_mem_we", bus.mem_we, c == 1);
            if (c == 1) begin
                check("s2_mem_addr", bus.mem_addr, 10'h010);
                check("s2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            end
            check("s2_d_valid", bus.d_valid, c == 2);
            check("s2_stall_mem", bus.stall_mem, c < 2);
            next_cycle();
        end
        bus.d_req = 0;
        data_req(1'b0, 10'h010, '0);
        next_cycle();

        // Simultaneous fetch and load: data first
        if_exp_q.push_back(ref_mem[10'h007]);
        d_model = ref_mem[10'h120];
        d_exp_q.push_back(d_model);
        bus.if_req = 1; bus.if_addr = 10'h007;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'h120;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            check("s3_d_valid", bus.d_valid, c == 4);
            check("s3_if_valid", bus.if_valid, c == 9);
            check("s3_mem_en", bus.mem_en, c == 1 || c == 6);
            if (c == 6) check("s3_fetch_addr", bus.mem_addr, 10'h007);
            check("s3_stall_if", bus.stall_if, c != 9);
            next_cycle();
            if (c == 4) bus.d_req = 0;
        end
        bus.if_req = 0;
        next_cycle();

        // Starvation guard: data, data, fetch, data, data
        gnt_addr_q.delete();
        gnt_starve_q.delete();
        fork
            fetch_req(10'h080);
            begin
                data_req(1'b0, 10'h180, '0);
                data_req(1'b0, 10'h181, '0);
                data_req(1'b0, 10'h182, '0);
                data_req(1'b0, 10'h183, '0);
            end
        join
        check("s4_grant_count", gnt_addr_q.size(), 5);
        if (gnt_addr_q.size() == 5) begin
            logic [ADDR_W-1:0] exp_addr [5];
            logic [1:0]        exp_stv  [5];
            exp_addr = '{10'h180, 10'h181, 10'h080, 10'h182, 10'h183};
            exp_stv  = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
            for (int i = 0; i < 5; i++) begin
                check("s4_grant_addr", gnt_addr_q[i], exp_addr[i]);
                check("s4_starve_cnt", gnt_starve_q[i], exp_stv[i]);
            end
        end
        next_cycle();

        // Reset in the middle of a load
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'h190;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("s5_mem_en_c1", bus.mem_en, 1);
        next_cycle();
        reset = 1'b1; bus.d_req = 0;
        next_cycle();
        reset = 1'b0;
        d_model = '0;
        if_exp_q.push_back(ref_mem[10'h033]);
        bus.if_req = 1; bus.if_addr = 10'h033;
        @(negedge clk);
        check("s5_state", dbg_state, 0);
        check("s5_busy", bus.busy, 0);
        check("s5_mem_en", bus.mem_en, 0);
        check("s5_mem_addr", bus.mem_addr, 0);
        check("s5_valids", {bus.if_valid, bus.d_valid}, 0);
        check("s5_d_rdata", bus.d_rdata, 0);
        check("s5_if_rdata", bus.if_rdata, 0);
        next_cycle();
        for (int c = 4; c <= 7; c++) begin
            @(negedge clk);
            check("s5_mem_en_fetch", bus.mem_en, c == 4);
            check("s5_if_valid", bus.if_valid, c == 7);
            next_cycle();
        end
        bus.if_req = 0;
        next_cycle();

        // Back-to-back fetches: one completion every 5 cycles
        if_cyc_q.delete();
        fetch_req(10'h041);
        fetch_req(10'h042);
        fetch_req(10'h043);
        check("s6_count", if_cyc_q.size(), 3);
        if (if_cyc_q.size() == 3) begin
            check("s6_period_a", if_cyc_q[1] - if_cyc_q[0], 5);
            check("s6_period_b", if_cyc_q[2] - if_cyc_q[1], 5);
        end

        // Random concurrent traffic: fetch reads 0x000-0x0FF, data 0x100-0x10F
        fork
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(0, 3)) next_cycle();
                fetch_req(10'($urandom_range(0, 255)));
            end
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(0, 3)) next_cycle();
                data_req(1'($urandom_range(0, 1)), 10'h100 + 10'($urandom_range(0, 15)), $urandom);
            end
        join
        repeat (2) next_cycle();
        check("end_if_queue_empty", if_exp_q.size(), 0);
        check("end_d_queue_empty", d_exp_q.size(), 0);
        check("end_idle", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the fetch stage (instruction reads) and the memory stage (loads and stores) of the 5-stage pipeline.
- Serialises the two requesters with one transaction outstanding at a time.
- Returns registered read data to each requester.
- Generates per-stage stall signals that feed the hazard-detection path, so the pipeline freezes while an access is pending.
- Data port normally wins, because it serves the older instruction. A starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 10: memory word-address width.
- DATA_W, 32: data width.
- MEM_LAT, 2: cycles from the mem_en cycle to valid mem_rdata. Must be ≥1.
- STARVE_MAX, 4: consecutive data grants, while fetch waits, after which fetch is granted once. Must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch read request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch address
- if_valid  out  1  one-cycle completion pulse for fetch
- if_rdata  out  DATA_W  fetch read data; held until next fetch completion
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_valid  out  1  one-cycle completion pulse for data port
- d_rdata  out  DATA_W  load data; held until next load completion
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, valid with mem_en
- mem_addr  out  ADDR_W  memory address, valid with mem_en
- mem_wdata  out  DATA_W  memory write data, valid with mem_en
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- stall_if  out  1  combinational: if_req & ~if_valid
- stall_mem  out  1  combinational: d_req & ~d_valid
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - state = IDLE.
  - All registered outputs (mem_*, if_valid, d_valid, if_rdata, d_rdata) = 0.
  - owner = none, lat_cnt = 0, starve_cnt = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, arbitration (evaluated at the clock edge):
  - Only one request pending: grant it.
  - Both pending: grant data, unless starve_cnt == STARVE_MAX, in which case grant fetch.
  - On a grant: latch owner, address, we and wdata, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_we = latched we (0 for fetch); mem_addr and mem_wdata driven from the latches.
  - Store: go to DONE.
  - Read: lat_cnt = MEM_LAT, go to WAIT.
- WAIT:
  - lat_cnt decrements each cycle.
  - When lat_cnt reaches 1, mem_rdata is captured into the owner's rdata register and the FSM goes to DONE.
- DONE (1 cycle):
  - Owner's valid = 1; the other valid stays 0.
  - Requests are ignored in this cycle so the completing request is not re-granted.
  - Go to IDLE.
- Latency, request high in cycle t:
  - Read: mem_en at t+1, mem_rdata sampled at t+1+MEM_LAT, valid at t+2+MEM_LAT.
  - Store: valid at t+2.
  - Earliest next grant: the cycle after DONE.
- Outside ISSUE, mem_en = 0 and mem_we = 0. mem_addr and mem_wdata hold their last values.
- starve_cnt:
  - Increments on each data grant made while if_req = 1, saturating at STARVE_MAX.
  - Clears on a fetch grant.
  - Clears in any IDLE cycle with if_req = 0.
- Stores never modify d_rdata.
- Requests arriving in ISSUE, WAIT or DONE wait; no queueing beyond the held request.
- Reset mid-operation:
  - The in-flight transaction is abandoned, no valid pulse is produced, and the FSM returns to IDLE.
  - A store already strobed into memory stands.
- Requester contract violations (changing addr or dropping req before valid) are undefined; the latched values are used.

Test Plan:
All scenarios use MEM_LAT=2 and STARVE_MAX=2.
1. Lone fetch: if_req=1, if_addr=0x005 at cycle 0 → mem_en=1, mem_addr=0x005, mem_we=0 at cycle 1; memory model drives 0x2002_0001 at cycle 3 → if_valid=1, if_rdata=0x2002_0001 at cycle 4. stall_if=1 in cycles 0–3 and 0 in cycle 4.
2. Store: d_req=1, d_we=1, d_addr=0x010, d_wdata=0xDEAD_BEEF at cycle 0 → mem_en=mem_we=1 with that addr/data at cycle 1, d_valid at cycle 2. d_rdata unchanged. Memory read-back of 0x010 returns 0xDEAD_BEEF.
3. Simultaneous fetch and load at cycle 0 → data granted first: d_valid at cycle 4, fetch mem_en at cycle 6, if_valid at cycle 9. stall_if stays 1 through cycle 8.
4. Starvation: d_req held continuously with new loads, if_req held → grant order data, data, fetch, data. starve_cnt reads 0→1→2→0.
5. Reset mid-read: load granted at cycle 0, reset=1 at cycle 2 → no d_valid; all outputs 0 at cycle 3. A new fetch at cycle 3 completes normally at cycle 7.
6. Back-to-back fetches: new if_addr presented the cycle after each if_valid → one completion every 5 cycles. mem_en never asserted in consecutive cycles.
